// File: rtl/edge_tune_scheduler.sv
// Frame-level sequencer: walks every source pixel, fetches its clamped 2x2 window,
// hands it to the tune block and writes one result slot per window.
module edge_tune_scheduler #(
    parameter int unsigned IMG_W   = 64,
    parameter int unsigned IMG_H   = 64,
    parameter int unsigned AW      = 12,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [15:0]   rd_data,
    output logic [15:0]   win_mn,
    output logic [15:0]   win_m1n,
    output logic [15:0]   win_mn1,
    output logic [15:0]   win_m1n1,
    output logic          win_valid,
    input  logic          tune_rdy,
    output logic          res_wr_en,
    output logic [AW-1:0] res_wr_addr,
    input  logic          res_wr_ready
);
    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_k, w_k_nxt;
    logic [CW-1:0]   r_col, w_col_nxt, w_m1;
    logic [RW-1:0]   r_row, w_row_nxt, w_n1;
    logic [TW-1:0]   r_wait, w_wait_nxt;
    logic            r_err, w_err_nxt;
    logic            w_advance, w_last;
    logic            r_busy, r_done, r_rd_en, r_win_valid, r_res_wr_en;
    logic            w_busy_nxt, w_done_nxt, w_rd_en_nxt, w_win_valid_nxt, w_res_wr_en_nxt;
    logic [AW-1:0]   r_rd_addr, w_rd_addr_nxt, r_res_wr_addr, w_res_wr_addr_nxt;
    logic [15:0]     r_win_mn, r_win_m1n, r_win_mn1, r_win_m1n1;

    function automatic logic [AW-1:0] f_addr(input logic [CW-1:0] c, input logic [RW-1:0] r);
        return AW'(r) * AW'(IMG_W) + AW'(c);
    endfunction

    assign w_last = (r_col == CW'(IMG_W - 1)) && (r_row == RW'(IMG_H - 1));

    // Next state, scan position and the next value of every registered output
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_wait_nxt  = r_wait;
        w_err_nxt   = r_err;
        w_advance   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_k_nxt     = 3'd0;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            S_FETCH: begin
                if (r_k == 3'd4) begin
                    w_state_nxt = S_ISSUE;
                    w_k_nxt     = 3'd0;
                end else begin
                    w_k_nxt = r_k + 3'd1;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_wait_nxt  = '0;
            end
            S_WAIT: begin
                if (tune_rdy) begin
                    w_state_nxt = S_WRITE;
                end else if (r_wait == TW'(TIMEOUT - 1)) begin
                    w_err_nxt = 1'b1;
                    w_advance = 1'b1;
                end else begin
                    w_wait_nxt = r_wait + TW'(1);
                end
            end
            S_WRITE: begin
                if (res_wr_ready) begin
                    w_advance = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Step to the next window; the last window closes the frame instead
        if (w_advance) begin
            if (w_last) begin
                w_state_nxt = S_DONE;
            end else begin
                w_state_nxt = S_FETCH;
                w_k_nxt     = 3'd0;
                if (r_col == CW'(IMG_W - 1)) begin
                    w_col_nxt = '0;
                    w_row_nxt = r_row + RW'(1);
                end else begin
                    w_col_nxt = r_col + CW'(1);
                end
            end
        end

        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_k_nxt     = r_k;
            w_col_nxt   = r_col;
            w_row_nxt   = r_row;
            w_wait_nxt  = r_wait;
            w_err_nxt   = r_err;
        end

        // Right/lower neighbours clamp at the image edge rather than wrapping
        w_m1 = (w_col_nxt == CW'(IMG_W - 1)) ? w_col_nxt : w_col_nxt + CW'(1);
        w_n1 = (w_row_nxt == RW'(IMG_H - 1)) ? w_row_nxt : w_row_nxt + RW'(1);

        w_busy_nxt        = (w_state_nxt != S_IDLE);
        w_done_nxt        = (w_state_nxt == S_DONE);
        w_win_valid_nxt   = (w_state_nxt == S_ISSUE);
        w_res_wr_en_nxt   = (w_state_nxt == S_WRITE);
        w_rd_en_nxt       = (w_state_nxt == S_FETCH) && (w_k_nxt != 3'd4);
        w_rd_addr_nxt     = r_rd_addr;
        w_res_wr_addr_nxt = r_res_wr_addr;
        if (w_rd_en_nxt) begin
            case (w_k_nxt[1:0])
                2'd0:    w_rd_addr_nxt = f_addr(w_col_nxt, w_row_nxt);
                2'd1:    w_rd_addr_nxt = f_addr(w_m1, w_row_nxt);
                2'd2:    w_rd_addr_nxt = f_addr(w_col_nxt, w_n1);
                default: w_rd_addr_nxt = f_addr(w_m1, w_n1);
            endcase
        end
        if (w_res_wr_en_nxt) begin
            w_res_wr_addr_nxt = f_addr(w_col_nxt, w_row_nxt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_wait        <= '0;
            r_err         <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rd_en       <= 1'b0;
            r_rd_addr     <= '0;
            r_win_valid   <= 1'b0;
            r_res_wr_en   <= 1'b0;
            r_res_wr_addr <= '0;
            r_win_mn      <= '0;
            r_win_m1n     <= '0;
            r_win_mn1     <= '0;
            r_win_m1n1    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_k           <= w_k_nxt;
            r_col         <= w_col_nxt;
            r_row         <= w_row_nxt;
            r_wait        <= w_wait_nxt;
            r_err         <= w_err_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_rd_en       <= w_rd_en_nxt;
            r_rd_addr     <= w_rd_addr_nxt;
            r_win_valid   <= w_win_valid_nxt;
            r_res_wr_en   <= w_res_wr_en_nxt;
            r_res_wr_addr <= w_res_wr_addr_nxt;
            // Read data lags rd_en by one cycle, so fetch step k lands word k-1
            if (r_state == S_FETCH) begin
                case (r_k)
                    3'd1:    r_win_mn   <= rd_data;
                    3'd2:    r_win_m1n  <= rd_data;
                    3'd3:    r_win_mn1  <= rd_data;
                    3'd4:    r_win_m1n1 <= rd_data;
                    default: ;
                endcase
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign rd_en       = r_rd_en;
    assign rd_addr     = r_rd_addr;
    assign win_mn      = r_win_mn;
    assign win_m1n     = r_win_m1n;
    assign win_mn1     = r_win_mn1;
    assign win_m1n1    = r_win_m1n1;
    assign win_valid   = r_win_valid;
    assign res_wr_en   = r_res_wr_en;
    assign res_wr_addr = r_res_wr_addr;
endmodule

// File: tb/tb_edge_tune_scheduler.sv
// Bench for edge_tune_scheduler: table of frame scenarios, randomized frames against a
// frame-level model, and directed abort / async-reset sequences.
module tb_edge_tune_scheduler;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;
    localparam int TO = 6;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic          busy, done, err, rd_en, win_valid, tune_rdy, res_wr_en, res_wr_ready;
    logic [AW-1:0] rd_addr, res_wr_addr;
    logic [15:0]   rd_data = '0;
    logic [15:0]   win_mn, win_m1n, win_mn1, win_m1n1;

    always #5 clk = ~clk;

    edge_tune_scheduler #(.IMG_W(W), .IMG_H(H), .AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done),
        .err(err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .win_mn(win_mn),
        .win_m1n(win_m1n), .win_mn1(win_mn1), .win_m1n1(win_m1n1), .win_valid(win_valid),
        .tune_rdy(tune_rdy), .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr),
        .res_wr_ready(res_wr_ready)
    );

    // Environment: pixel memory, tune responder with per-window delay, stalling result sink
    logic [15:0] mem [16];
    int          tdel [N];
    int          rstall [16];
    logic        tune_m = 1'b0, tune_force = 1'b0, tpend = 1'b0;
    int          widx = 0, tcnt = 0, scnt = 0;

    assign tune_rdy     = tune_m | tune_force;
    assign res_wr_ready = res_wr_en && (scnt >= rstall[res_wr_addr]);

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
    always @(posedge clk) scnt <= (res_wr_en && !res_wr_ready) ? scnt + 1 : 0;

    always @(posedge clk) begin
        tune_m <= 1'b0;
        if (start && !busy) begin
            widx  <= 0;
            tpend <= 1'b0;
        end else if (win_valid) begin
            widx <= widx + 1;
            if (tdel[widx % N] == 0) tune_m <= 1'b1;
            else begin
                tpend <= 1'b1;
                tcnt  <= tdel[widx % N] - 1;
            end
        end else if (tpend) begin
            if (tcnt == 0) begin
                tune_m <= 1'b1;
                tpend  <= 1'b0;
            end else tcnt <= tcnt - 1;
        end
    end

    // Monitor
    int          got_rd[$], got_wr[$];
    logic [63:0] got_win[$];
    logic [63:0] cur_win = '0;
    int          done_cnt = 0, busy_cnt = 0, unstable = 0;
    logic        mon_clr = 1'b0;

    always @(posedge clk) begin
        if (mon_clr) begin
            got_rd.delete();
            got_wr.delete();
            got_win.delete();
            done_cnt <= 0;
            busy_cnt <= 0;
            unstable <= 0;
        end else begin
            if (rd_en) got_rd.push_back(int'(rd_addr));
            if (res_wr_en && res_wr_ready) got_wr.push_back(int'(res_wr_addr));
            if (win_valid) begin
                got_win.push_back({win_mn, win_m1n, win_mn1, win_m1n1});
                cur_win <= {win_mn, win_m1n, win_mn1, win_m1n1};
            end
            if (res_wr_en && ({win_mn, win_m1n, win_mn1, win_m1n1} != cur_win)) unstable <= unstable + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
        end
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Frame-level model: clamped window addresses, writes for windows answered in time, cycle cost
    int          exp_rd[$], exp_wr[$];
    logic [63:0] exp_win[$];
    logic        exp_err;
    int          exp_busy;

    function automatic int pa(input int c, input int r);
        return r * W + c;
    endfunction

    task automatic build_model();
        exp_rd.delete();
        exp_wr.delete();
        exp_win.delete();
        exp_err  = 1'b0;
        exp_busy = 1;
        for (int j = 0; j < N; j++) begin
            int c, r, c1, r1;
            int a [4];
            c  = j % W;
            r  = j / W;
            c1 = (c + 1 < W) ? c + 1 : W - 1;
            r1 = (r + 1 < H) ? r + 1 : H - 1;
            a  = '{pa(c, r), pa(c1, r), pa(c, r1), pa(c1, r1)};
            for (int q = 0; q < 4; q++) exp_rd.push_back(a[q]);
            exp_win.push_back({mem[a[0]], mem[a[1]], mem[a[2]], mem[a[3]]});
            if (tdel[j] < TO) begin
                exp_wr.push_back(pa(c, r));
                exp_busy += 6 + (tdel[j] + 1) + (rstall[j] + 1);
            end else begin
                exp_err = 1'b1;
                exp_busy += 6 + TO;
            end
        end
    endtask

    task automatic setup_frame(input bit rnd);
        for (int a = 0; a < 16; a++) begin
            mem[a]    = rnd ? 16'($urandom) : 16'(a);
            rstall[a] = 0;
        end
        for (int j = 0; j < N; j++) tdel[j] = 0;
    endtask

    task automatic pulse_start();
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input int force_win, input bit glitch);
        bit found;
        int nwin;
        found = 1'b0;
        nwin  = 0;
        pulse_start();
        chk("err_cleared_on_start", err, 0);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            tune_force = 1'b0;
            start = (glitch && i == 0);
            if (win_valid) begin
                if (nwin == force_win) tune_force = 1'b1;
                nwin++;
            end
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        start = 1'b0;
        tune_force = 1'b0;
        chk("done_seen", found, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame();
        chk("rd_count", got_rd.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
            chk($sformatf("rd_addr[%0d]", i), got_rd[i], exp_rd[i]);
        chk("wr_count", got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            chk($sformatf("wr_addr[%0d]", i), got_wr[i], exp_wr[i]);
        chk("win_count", got_win.size(), exp_win.size());
        for (int i = 0; i < exp_win.size() && i < got_win.size(); i++)
            chk($sformatf("window[%0d]", i), got_win[i], exp_win[i]);
        chk("err_after_frame", err, exp_err);
        chk("done_count", done_cnt, 1);
        chk("busy_cycles", busy_cnt, exp_busy);
        chk("win_stable_in_write", unstable, 0);
        chk("idle_after_frame", busy, 0);
    endtask

    typedef struct {
        int   twin;
        int   tdly;
        int   rwin;
        int   rlen;
        int   exp_writes;
        logic exp_err;
        int   exp_busy;
    } scen_t;

    scen_t tbl [5];

    initial begin
        bit found;
        int idle_bad;

        tbl[0] = '{0, 0, 0, 0, 12, 1'b0, 97};
        tbl[1] = '{5, TO, 0, 0, 11, 1'b1, 101};
        tbl[2] = '{0, 0, 2, 3, 12, 1'b0, 100};
        tbl[3] = '{7, TO - 1, 0, 0, 12, 1'b0, 102};
        tbl[4] = '{11, TO + 3, 0, 0, 11, 1'b1, 101};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        setup_frame(1'b0);
        #12;
        chk("reset_ctrl", {busy, done, err, rd_en, win_valid, res_wr_en}, 0);
        chk("reset_addrs", {rd_addr, res_wr_addr}, 0);
        chk("reset_window", {win_mn, win_m1n, win_mn1, win_m1n1}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_without_start", {busy, rd_en}, 0);

        for (int s = 0; s < 5; s++) begin
            setup_frame(1'b0);
            if (tbl[s].tdly != 0) tdel[tbl[s].twin] = tbl[s].tdly;
            rstall[tbl[s].rwin] = tbl[s].rlen;
            build_model();
            run_frame(-1, 1'b0);
            check_frame();
            chk($sformatf("tbl%0d_writes", s), got_wr.size(), tbl[s].exp_writes);
            chk($sformatf("tbl%0d_err", s), err, tbl[s].exp_err);
            chk($sformatf("tbl%0d_busy", s), busy_cnt, tbl[s].exp_busy);
            if (s == 0) begin
                chk("win_0_0", (got_win.size() > 0) ? got_win[0] : '0, 64'h0000_0001_0004_0005);
                chk("win_3_0_clamp", (got_win.size() > 3) ? got_win[3] : '0, 64'h0003_0003_0007_0007);
                for (int q = 44; q < 48; q++)
                    chk($sformatf("clamp_rd[%0d]", q), (got_rd.size() > q) ? got_rd[q] : 0, 11);
            end
        end

        // tune_rdy during ISSUE must be ignored, so window 4 still times out
        setup_frame(1'b0);
        tdel[4] = TO;
        build_model();
        run_frame(4, 1'b0);
        check_frame();

        for (int f = 0; f < 4; f++) begin
            setup_frame(1'b1);
            for (int j = 0; j < N; j++) begin
                int r;
                r = int'($urandom_range(0, 9));
                tdel[j] = (r < 6) ? r % 4 : ((r < 8) ? TO - 1 : TO);
                rstall[j] = int'($urandom_range(0, 2));
            end
            build_model();
            run_frame(-1, f[0]);
            check_frame();
        end

        // Abort while waiting on the tune block
        setup_frame(1'b0);
        tdel[0] = TO;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (win_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_reach_issue", found, 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_strobes", {rd_en, res_wr_en, win_valid}, 0);
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_rd_count", got_rd.size(), 4);
        chk("abort_no_write", got_wr.size(), 0);
        chk("abort_err_hold", err, 0);
        tdel[0] = 0;
        build_model();
        run_frame(-1, 1'b0);
        check_frame();

        // Asynchronous reset while a write is stalled
        setup_frame(1'b0);
        rstall[3] = 10;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (res_wr_en && res_wr_addr == AW'(3)) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_write3", found, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_busy", busy, 0);
        chk("rst_async_wr", {res_wr_en, res_wr_addr}, 0);
        chk("rst_async_outs", {rd_en, rd_addr, win_valid, done, err}, 0);
        chk("rst_async_win", {win_mn, win_m1n, win_mn1, win_m1n1}, 0);
        @(negedge clk);
        reset = 1'b0;
        idle_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || rd_en || res_wr_en || win_valid) idle_bad++;
        end
        chk("idle_after_reset", idle_bad, 0);
        rstall[3] = 0;
        build_model();
        run_frame(-1, 1'b0);
        check_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
